// File: rtl/irb_scanout.sv
// irb_scanout: reads the processed 8x8 image back out of the IRB once the LCD
// controller reports done, and streams it in raster order to the panel driver.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse that begins a frame readout (ignored while busy)
//   irb_q             IRB read data, valid the cycle after the address edge
//   irb_cen, irb_a    IRB chip enable (active low) and read address
//   pix_data/row/col  current pixel value and its position
//   pix_valid/ready   output handshake
//   frame_last        current pixel is the last of the frame
//   busy              frame readout in progress
//   frame_done        one-cycle pulse after the final handshake
//   checksum          (only with SCANOUT_CHECKSUM_EN) 16-bit sum of the frame's pixels
//   state_dbg         current FSM state, for observation only
//
// Optional feature macro: SCANOUT_CHECKSUM_EN.
//
// Handshake: a pixel moves when pix_valid && pix_ready at a rising edge; while
// pix_valid=1 and pix_ready=0 every pix_* output holds its value.
module irb_scanout #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int DW    = 8,
   parameter int AW    = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [DW-1:0]              irb_q,
   output logic                       irb_cen,
   output logic [AW-1:0]              irb_a,
   output logic [DW-1:0]              pix_data,
   output logic                       pix_valid,
   input  logic                       pix_ready,
   output logic [$clog2(IMG_H)-1:0]   pix_row,
   output logic [$clog2(IMG_W)-1:0]   pix_col,
   output logic                       frame_last,
   output logic                       busy,
`ifdef SCANOUT_CHECKSUM_EN
   output logic [15:0]                checksum,
`endif
   output logic                       frame_done,
   output logic [1:0]                 state_dbg
);

   localparam int CW = $clog2(IMG_W);
   localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

   state_t        state;
   // The pix_* register is the buffer head; skid0/skid1 are the two entries
   // behind it. Together with the read on the bus this covers the 2-cycle
   // issue-to-capture loop, so a constantly ready consumer sees no bubbles.
   logic [DW-1:0] skid0, skid1;
   logic [1:0]    occ;
   logic          in_flight;   // irb_q carries data for the buffer this cycle
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] out_cnt;

   logic          pop, out_free, ov_n, issue_n, in_flight_n;
   logic [DW-1:0] od_n, sk0_n, sk1_n;
   logic [1:0]    occ_n;
   logic [AW-1:0] out_cnt_n;

   assign state_dbg = state;

   always_comb begin
      pop         = pix_valid & pix_ready;
      out_free    = ~pix_valid | pop;
      ov_n        = pix_valid;
      od_n        = pix_data;
      sk0_n       = skid0;
      sk1_n       = skid1;
      occ_n       = occ;
      if (out_free) begin
         if (occ != 2'd0) begin
            // head refills from the oldest skid entry; a returning read joins the tail
            od_n  = skid0;
            ov_n  = 1'b1;
            sk0_n = skid1;
            occ_n = occ - 2'd1;
            if (in_flight) begin
               if (occ == 2'd1) sk0_n = irb_q;
               else             sk1_n = irb_q;
               occ_n = occ;
            end
         end else if (in_flight) begin
            od_n = irb_q;
            ov_n = 1'b1;
         end else begin
            ov_n = 1'b0;
         end
      end else if (in_flight) begin
         if (occ == 2'd0) sk0_n = irb_q;
         else             sk1_n = irb_q;
         occ_n = occ + 2'd1;
      end
      out_cnt_n   = pop ? out_cnt + AW'(1) : out_cnt;
      in_flight_n = ~irb_cen;
      // Room check looks at the buffer as it will be during the issue cycle.
      case (state)
         IDLE:    issue_n = start;
         READ:    issue_n = (({1'b0, occ_n} + {2'b00, in_flight_n}) < 3'd2);
         default: issue_n = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         irb_cen    <= 1'b1;
         irb_a      <= '0;
         pix_data   <= '0;
         pix_valid  <= 1'b0;
         pix_row    <= '0;
         pix_col    <= '0;
         frame_last <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         skid0      <= '0;
         skid1      <= '0;
         occ        <= 2'd0;
         in_flight  <= 1'b0;
         rd_addr    <= '0;
         out_cnt    <= '0;
`ifdef SCANOUT_CHECKSUM_EN
         checksum   <= 16'h0000;
`endif
      end else begin
         in_flight  <= in_flight_n;
         skid0      <= sk0_n;
         skid1      <= sk1_n;
         occ        <= occ_n;
         out_cnt    <= out_cnt_n;
         pix_valid  <= ov_n;
         pix_data   <= od_n;
         pix_row    <= out_cnt_n[AW-1:CW];
         pix_col    <= out_cnt_n[CW-1:0];
         frame_last <= ov_n && (out_cnt_n == LAST);
         irb_cen    <= ~issue_n;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= READ;
                  busy    <= 1'b1;
                  irb_a   <= '0;
                  rd_addr <= AW'(1);
               end
            end
            READ: begin
               if (issue_n) begin
                  irb_a   <= rd_addr;
                  rd_addr <= rd_addr + AW'(1);
                  if (rd_addr == LAST) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && out_cnt == LAST) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef SCANOUT_CHECKSUM_EN
         if (state == IDLE && start) checksum <= 16'h0000;
         else if (pop)               checksum <= checksum + 16'(pix_data);
`endif
      end
   end

endmodule

// File: tb/tb_irb_scanout.sv
module tb_irb_scanout;
   localparam int IMG_W = 8;
   localparam int IMG_H = 8;
   localparam int DW    = 8;
   localparam int AW    = 6;
   localparam int N     = IMG_W * IMG_H;

   logic          clk = 1'b0;
   logic          reset, start, pix_ready;
   logic [DW-1:0] irb_q;
   logic          irb_cen, pix_valid, frame_last, busy, frame_done;
   logic [AW-1:0] irb_a;
   logic [DW-1:0] pix_data;
   logic [2:0]    pix_row, pix_col;
   logic [1:0]    state_dbg;
`ifdef SCANOUT_CHECKSUM_EN
   logic [15:0]   checksum;
`endif

   always #5 clk = ~clk;

   irb_scanout #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .irb_q(irb_q),
      .irb_cen(irb_cen), .irb_a(irb_a), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_row(pix_row),
      .pix_col(pix_col), .frame_last(frame_last), .busy(busy),
`ifdef SCANOUT_CHECKSUM_EN
      .checksum(checksum),
`endif
      .frame_done(frame_done), .state_dbg(state_dbg)
   );

   // IRB: synchronous read, data on irb_q the cycle after the address edge
   logic [DW-1:0] mem [N];
   always @(posedge clk) begin
      if (!irb_cen) irb_q <= mem[irb_a];
      else          irb_q <= DW'($urandom);
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ready pattern: 0 = always 1, 1 = 1,0,0,1,0 repeating, 2 = random
   int ready_mode = 0;
   int phase = 0;
   always @(negedge clk) begin
      case (ready_mode)
         0:       pix_ready = 1'b1;
         1:       pix_ready = (phase % 5 == 0) || (phase % 5 == 3);
         default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
   end

   // Behavioural model: a frame is the list mem[0..N-1] delivered in order,
   // pixel k at (k/IMG_W, k%IMG_W); at most 3 pixels may be read but not yet taken.
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int            cyc = 0;
   bit            m_active = 0, m_busy = 0, m_done = 0, m_seen_first = 0;
   int            m_xfer = 0, m_issued = 0, m_start_cyc = 0, m_first_cyc = 0;
   int            frames_done = 0;
   logic [15:0]   m_sum = 16'h0;

   always @(posedge clk) begin
      bit old_active;
      cyc++;
      if (reset) begin
         m_active = 0; m_busy = 0; m_done = 0;
         m_xfer = 0; m_issued = 0;
         exp_q.delete();
      end else begin
         old_active = m_active;
         m_done = 0;
         if (!irb_cen) begin
            check("read_while_idle", 32'(old_active), 32'd1);
            check("read_addr", 32'(irb_a), 32'(m_issued % N));
            check("read_room", 32'(m_issued - m_xfer <= 2), 32'd1);
            m_issued++;
         end
         if (old_active && pix_valid && !m_seen_first) begin
            m_seen_first = 1;
            m_first_cyc = cyc;
            check("first_valid_latency", 32'(cyc - m_start_cyc), 32'd3);
         end
         if (pix_valid && pix_ready) begin
            if (!old_active) begin
               check("handshake_while_idle", 32'd1, 32'd0);
            end else begin
               got_q.push_back(pix_data);
               m_sum = m_sum + 16'(pix_data);
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               m_xfer++;
               if (m_xfer == N) begin
                  m_active = 0; m_busy = 0; m_done = 1;
                  frames_done++;
                  if (ready_mode == 0) check("no_bubbles", 32'(cyc - m_first_cyc), 32'd63);
               end
            end
         end
         if (start && !old_active) begin
            m_active = 1; m_busy = 1; m_seen_first = 0;
            m_xfer = 0; m_issued = 0; m_start_cyc = cyc; m_sum = 16'h0;
            exp_q.delete();
            got_q.delete();
            for (int k = 0; k < N; k++) exp_q.push_back(mem[k]);
         end
      end
   end

   // Compare process: DUT outputs against the model, every cycle out of reset
   always @(negedge clk) begin
      if (!reset) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("frame_done", 32'(frame_done), 32'(m_done));
         if (pix_valid) begin
            check("pix_data", 32'(pix_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hdead);
            check("pix_row", 32'(pix_row), 32'(m_xfer / IMG_W));
            check("pix_col", 32'(pix_col), 32'(m_xfer % IMG_W));
            check("frame_last", 32'(frame_last), 32'(m_xfer == N - 1));
         end else begin
            check("frame_last_no_valid", 32'(frame_last), 32'd0);
         end
         if (!m_active) check("valid_while_idle", 32'(pix_valid), 32'd0);
`ifdef SCANOUT_CHECKSUM_EN
         if (m_done) check("checksum_model", 32'(checksum), 32'(m_sum));
`endif
      end
   end

   task automatic start_frame();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int f0 = frames_done;
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (frames_done != f0) ok = 1;
      end
      check("wait_frame_done", 32'(ok), 32'd1);
   endtask

   task automatic wait_xfer(input int n, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (m_active && m_xfer >= n) ok = 1;
      end
      check("wait_transfers", 32'(ok), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_irb_cen"}, 32'(irb_cen), 32'd1);
      check({tag, "_irb_a"}, 32'(irb_a), 32'd0);
      check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
      check({tag, "_pix_rowcol"}, 32'({pix_row, pix_col}), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      pix_ready = 1'b1;
      for (int k = 0; k < N; k++) mem[k] = '0;

      // reset only
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;

      // mem[k]=k, consumer always ready
      for (int k = 0; k < N; k++) mem[k] = DW'(k);
      ready_mode = 0;
      start_frame();
      wait_done(300);
      check("ramp_count", 32'(got_q.size()), 32'd64);
      check("ramp_first", 32'(got_q[0]), 32'h00);
      check("ramp_last", 32'(got_q[63]), 32'h3F);
`ifdef SCANOUT_CHECKSUM_EN
      check("ramp_checksum", 32'(checksum), 32'h07E0);
`endif

      // mem[k]=FF-k, ready 1,0,0,1,0
      for (int k = 0; k < N; k++) mem[k] = DW'(8'hFF - k);
      ready_mode = 1;
      phase = 0;
      start_frame();
      wait_done(600);
      check("down_count", 32'(got_q.size()), 32'd64);
      check("down_first", 32'(got_q[0]), 32'hFF);
      check("down_last", 32'(got_q[63]), 32'hC0);

      // random data, random ready, extra start at pixel 10, start on frame_done
      for (int k = 0; k < N; k++) mem[k] = DW'($urandom);
      ready_mode = 2;
      start_frame();
      wait_xfer(10, 400);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(800);
      check("restart_ignored_count", 32'(got_q.size()), 32'd64);
      start = 1'b1;                   // in the frame_done cycle
      @(negedge clk) start = 1'b0;
      check("start_on_done_busy", 32'(busy), 32'd1);
      wait_done(800);
      check("b2b_first", 32'(got_q[0]), 32'(mem[0]));
      check("b2b_count", 32'(got_q.size()), 32'd64);

      // reset after 20 transfers aborts, next frame starts over
      for (int k = 0; k < N; k++) mem[k] = DW'($urandom);
      start_frame();
      wait_xfer(20, 800);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("abort");
      reset = 1'b0;
      start_frame();
      wait_done(800);
      check("after_abort_first", 32'(got_q[0]), 32'(mem[0]));
      check("after_abort_count", 32'(got_q.size()), 32'd64);

      // all-FF frame
      for (int k = 0; k < N; k++) mem[k] = 8'hFF;
      ready_mode = 0;
      start_frame();
      wait_done(300);
      check("ff_last", 32'(got_q[63]), 32'hFF);
`ifdef SCANOUT_CHECKSUM_EN
      check("ff_checksum", 32'(checksum), 32'h3FC0);
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irb_scanout.md
Name: irb_scanout

Overview:
- Downstream of the LCD controller: once the controller signals done, this block reads the 8x8 processed image back out of the IRB.
- Read port: synchronous single-port SRAM, 1-cycle read latency, active-low chip enable.
- Streams pixels in raster order over a valid/ready interface toward the panel driver.
- Holds a 2-entry output buffer, so back-pressure never drops or duplicates a pixel.

Parameters:
- IMG_W, 8, image width in pixels (power of 2).
- IMG_H, 8, image height in pixels (power of 2).
- DW, 8, pixel width in bits.
- AW, 6, IRB address width; must equal log2(IMG_W*IMG_H).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, driven by the controller's done; begins a frame readout.
- irb_q  in  DW  IRB read data, valid the cycle after the address edge.
- irb_cen  out  1  IRB chip enable, active low; write enable is tied to read at top level.
- irb_a  out  AW  IRB read address.
- pix_data  out  DW  pixel value.
- pix_valid  out  1  pix_data, pix_row, pix_col and frame_last are valid.
- pix_ready  in  1  consumer accepts the pixel.
- pix_row  out  log2(IMG_H)  row of the current pixel.
- pix_col  out  log2(IMG_W)  column of the current pixel.
- frame_last  out  1  current pixel is the final pixel of the frame.
- busy  out  1  frame readout in progress.
- frame_done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (synchronous, overrides everything):
  - state=IDLE; irb_cen=1; irb_a=0; all pix_* outputs=0; busy=0; frame_done=0.
  - Buffer emptied; read and output counters cleared.
- Registered outputs: irb_cen, irb_a, pix_*, busy, frame_done.
- Handshake: a transfer occurs when pix_valid && pix_ready on a rising edge.
  - While pix_valid=1 and pix_ready=0, pix_* are held stable.
- State machine:
  - IDLE: start=1 -> READ; busy=1 from the next cycle.
  - READ: issue reads in order, addr = row*IMG_W + col, addresses 0..IMG_W*IMG_H-1.
    - A read is issued (irb_cen=0) only when occupancy + in_flight < 2.
    - Otherwise irb_cen=1 and irb_a holds its value.
    - After the final address is issued -> DRAIN.
  - DRAIN: no reads (irb_cen=1); wait for the buffer to empty through handshakes.
    - The last handshake -> IDLE, with busy=0 and frame_done=1 for exactly one cycle.
- Data path:
  - irb_q is captured into the buffer on the edge after the read cycle.
  - The buffer head drives pix_data.
  - pix_row and pix_col come from an output-side counter; they advance only on a handshake.
  - Row-major order; col wraps IMG_W-1 -> 0 and increments row.
  - frame_last=1 exactly when the output counter equals IMG_W*IMG_H-1 and pix_valid=1.
- Latency:
  - start is sampled at edge E0; irb_cen=0 and irb_a=0 after E0.
  - IRB captures at E1; first pix_valid=1 after E2.
- Throughput: with pix_ready held 1, one pixel per cycle with no bubbles.
  - 64 pixels occupy 64 consecutive cycles.
  - frame_done rises the cycle after the final handshake.
- Boundaries:
  - start while busy is ignored; no restart, no state change.
  - start in the same cycle as the frame_done pulse is accepted, because the block is already in IDLE.
  - When the buffer is full and a handshake occurs in the same cycle a read returns, the pop and the push are both performed; no loss.
  - Reset mid-frame aborts immediately. The next start reads from address 0.
- In-flight reads: the block tracks at most 1 in-flight read at a time.

Optional Feature:
- Macro SCANOUT_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (16 bits).
  - The running sum, modulo 2^16, of every pixel transferred by handshake in the current frame.
  - Cleared to 0 when a start is accepted.
  - Stable and valid from the frame_done cycle until the next accepted start.
  - Reset value 0.
- Undefined: the port and the accumulator are absent. All other behaviour is identical.

Test Plan:
- Reset only -> after 2 cycles of reset=1: irb_cen=1, pix_valid=0, busy=0, frame_done=0, irb_a=0.
- IRB mem[k]=k, start pulse, pix_ready=1 constant -> pix_valid rises 2 edges after start.
  - Data 0x00..0x3F is delivered on 64 consecutive cycles.
  - row/col go (0,0)..(7,7); frame_last only on 0x3F.
  - frame_done pulses once, the cycle after that pixel.
- IRB mem[k]=8'hFF-k, pix_ready pattern 1,0,0,1,0 repeating -> exactly 64 transfers, values 0xFF..0xC0 in order.
  - pix_data stays stable while ready=0.
  - irb_cen=1 whenever the buffer holds 2 entries.
- A second start at pixel 10 of a frame -> ignored; the stream continues from 11.
  - After frame_done, a new start re-reads from address 0.
- reset asserted after 20 transfers -> outputs return to reset values the next cycle.
  - A following start delivers pixel (0,0) with value mem[0].
- With SCANOUT_CHECKSUM_EN and mem[k]=k -> checksum=16'h07E0 at frame_done.
  - With mem[k]=8'hFF -> checksum=16'h3FC0.
